// File: rtl/upstream_link_supervisor.sv
// Bring-up and recovery controller for one Aurora 8B10B upstream channel.
// Sequences gt_reset / reset, waits for TX PLL lock and channel-up with
// timeouts, supervises the live link and retries with back-off.
module upstream_link_supervisor #(
    parameter int unsigned GT_RST_CYCLES   = 128,
    parameter int unsigned SYS_RST_CYCLES  = 256,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned CHAN_TIMEOUT    = 1048576,
    parameter int unsigned BACKOFF_CYCLES  = 4096,
    parameter int unsigned MAX_RETRY       = 8,
    parameter int unsigned SOFT_ERR_LIMIT  = 16,
    parameter int unsigned SOFT_ERR_WINDOW = 65536
) (
    input  logic        clk_init,
    input  logic        rst,
    input  logic        restart,
    input  logic        tx_lock,
    input  logic        channel_up,
    input  logic        hard_err,
    input  logic        soft_err,
    output logic        gt_reset,
    output logic        sys_reset,
    output logic        link_ok,
    output logic [2:0]  state,
    output logic [7:0]  retry_cnt,
    output logic [15:0] soft_err_cnt
);

    localparam int TW = 32;

    typedef enum logic [2:0] {
        ST_GT_RST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SYS_RST   = 3'd2,
        ST_WAIT_CHAN = 3'd3,
        ST_UP        = 3'd4,
        ST_BACKOFF   = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [TW-1:0]  timer_reg;
    logic [TW-1:0]  win_timer_reg;
    logic [15:0]    win_cnt_reg;
    logic [7:0]     retry_cnt_reg;
    logic [15:0]    soft_err_cnt_reg;

    // Aurora status bits, one synchronizer per bit
    logic [3:0] async_in;
    logic [3:0] meta_reg;
    logic [3:0] sync_reg;
    logic       soft_err_d_reg;

    logic tx_lock_s;
    logic channel_up_s;
    logic hard_err_s;
    logic soft_err_s;
    logic soft_edge;
    logic retry_exhausted;
    logic win_rollover;

    assign async_in = {soft_err, hard_err, channel_up, tx_lock};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            // Two-flop synchronizer for an asynchronous Aurora status bit
            always_ff @(posedge clk_init or posedge rst) begin
                if (rst) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= async_in[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign tx_lock_s    = sync_reg[0];
    assign channel_up_s = sync_reg[1];
    assign hard_err_s   = sync_reg[2];
    assign soft_err_s   = sync_reg[3];

    // Delayed copy of soft_err_s for rising-edge detection
    always_ff @(posedge clk_init or posedge rst) begin
        if (rst) begin
            soft_err_d_reg <= 1'b0;
        end else begin
            soft_err_d_reg <= soft_err_s;
        end
    end

    assign soft_edge       = soft_err_s & ~soft_err_d_reg;
    assign retry_exhausted = (MAX_RETRY != 0) && (32'(retry_cnt_reg) >= MAX_RETRY);
    assign win_rollover    = (win_timer_reg == TW'(SOFT_ERR_WINDOW - 1));

    // Next-state selection; success beats timeout, restart beats everything
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_GT_RST: begin
                if (timer_reg == TW'(GT_RST_CYCLES - 1)) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (tx_lock_s) state_next = ST_SYS_RST;
                else if (timer_reg == TW'(LOCK_TIMEOUT - 1)) state_next = ST_BACKOFF;
            end
            ST_SYS_RST: begin
                if (timer_reg == TW'(SYS_RST_CYCLES - 1)) state_next = ST_WAIT_CHAN;
            end
            ST_WAIT_CHAN: begin
                if (channel_up_s) state_next = ST_UP;
                else if (timer_reg == TW'(CHAN_TIMEOUT - 1)) state_next = ST_BACKOFF;
            end
            ST_UP: begin
                if (!channel_up_s || hard_err_s || (win_cnt_reg >= 16'(SOFT_ERR_LIMIT)))
                    state_next = ST_BACKOFF;
            end
            ST_BACKOFF: begin
                if (timer_reg == TW'(BACKOFF_CYCLES - 1))
                    state_next = retry_exhausted ? ST_FAIL : ST_GT_RST;
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_GT_RST;
            end
        endcase
        if (restart) state_next = ST_GT_RST;
    end

    // State register with outputs decoded from the next state
    always_ff @(posedge clk_init or posedge rst) begin
        if (rst) begin
            state_reg <= ST_GT_RST;
            gt_reset  <= 1'b1;
            sys_reset <= 1'b1;
            link_ok   <= 1'b0;
        end else begin
            state_reg <= state_next;
            gt_reset  <= (state_next == ST_GT_RST) || (state_next == ST_BACKOFF) ||
                         (state_next == ST_FAIL);
            sys_reset <= !((state_next == ST_WAIT_CHAN) || (state_next == ST_UP));
            link_ok   <= (state_next == ST_UP);
        end
    end

    // Per-state timer: cleared on entry, idle in the untimed states
    always_ff @(posedge clk_init or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (restart || (state_next != state_reg)) begin
            timer_reg <= '0;
        end else if ((state_reg != ST_UP) && (state_reg != ST_FAIL)) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    // Retry and soft-error totals, both saturating
    always_ff @(posedge clk_init or posedge rst) begin
        if (rst) begin
            retry_cnt_reg    <= '0;
            soft_err_cnt_reg <= '0;
        end else if (restart) begin
            retry_cnt_reg    <= '0;
            soft_err_cnt_reg <= '0;
        end else begin
            if ((state_next == ST_BACKOFF) && (state_reg != ST_BACKOFF) &&
                (retry_cnt_reg != 8'hFF))
                retry_cnt_reg <= retry_cnt_reg + 8'd1;
            if (soft_edge && (soft_err_cnt_reg != 16'hFFFF))
                soft_err_cnt_reg <= soft_err_cnt_reg + 16'd1;
        end
    end

    // Soft-error window: only runs while staying in UP, restarts on UP entry
    always_ff @(posedge clk_init or posedge rst) begin
        if (rst) begin
            win_timer_reg <= '0;
            win_cnt_reg   <= '0;
        end else if ((state_reg == ST_UP) && (state_next == ST_UP)) begin
            if (win_rollover) begin
                win_timer_reg <= '0;
                win_cnt_reg   <= 16'(soft_edge);
            end else begin
                win_timer_reg <= win_timer_reg + 1'b1;
                win_cnt_reg   <= win_cnt_reg + 16'(soft_edge);
            end
        end else begin
            win_timer_reg <= '0;
            win_cnt_reg   <= '0;
        end
    end

    assign state        = state_reg;
    assign retry_cnt    = retry_cnt_reg;
    assign soft_err_cnt = soft_err_cnt_reg;

endmodule
